// File: rtl/sort_pkg.sv
// Types and defaults shared between the entry loader and the bubble-sort datapath.
package sort_pkg;

    localparam int unsigned SORT_DATA_W    = 4;
    localparam int unsigned SORT_N_ENTRIES = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        SORT    = 2'd2
    } sort_state_t;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low button -> 2-FF synchronizer -> debounce counter -> one-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_d1;
    logic             armed_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            level_q  <= 1'b1;
            level_d1 <= 1'b1;
            cnt_q    <= '0;
            fill_q   <= '0;
            armed_q  <= 1'b0;
        end else begin
            sync_q1  <= key_n;
            sync_q2  <= sync_q1;
            fill_q   <= {fill_q[0], 1'b1};
            level_d1 <= level_q;
            // Only arm once a real released level has come through the synchronizer,
            // so a button held across reset cannot produce a press.
            if (fill_q[1] && sync_q2) begin
                armed_q <= 1'b1;
            end
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q2;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = armed_q & level_d1 & ~level_q;

endmodule

// File: rtl/sort_entry_loader.sv
// Collects N_ENTRIES switch values on debounced load presses, then launches the sort on a go press.
module sort_entry_loader
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W          = SORT_DATA_W,
    parameter int unsigned N_ENTRIES       = SORT_N_ENTRIES,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_n,
    input  logic                              go_n,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              sort_done,
    output logic [N_ENTRIES*DATA_W-1:0]       entries,
    output logic [$clog2(N_ENTRIES+1)-1:0]    entry_cnt,
    output logic                              full,
    output logic                              start,
    output logic                              busy
);

    localparam int unsigned CNT_W = $clog2(N_ENTRIES + 1);

    sort_state_t       state_q;
    sort_state_t       state_d;
    logic              load_ev;
    logic              go_ev;
    logic              wr_en;
    logic              start_d;
    logic              clr_cnt;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] entry_q [N_ENTRIES];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (load_n),
        .press (load_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (go_n),
        .press (go_ev)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        start_d = 1'b0;
        clr_cnt = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (load_ev && (cnt_q < CNT_W'(N_ENTRIES))) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_W'(N_ENTRIES - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (go_ev) begin
                    start_d = 1'b1;
                    state_d = SORT;
                end
            end
            SORT: begin
                if (sort_done) begin
                    clr_cnt = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int unsigned k = 0; k < N_ENTRIES; k++) begin
                entry_q[k] <= '0;
            end
        end else begin
            if (clr_cnt) begin
                cnt_q <= '0;
            end else if (wr_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            for (int unsigned k = 0; k < N_ENTRIES; k++) begin
                if (wr_en && (cnt_q == CNT_W'(k))) begin
                    entry_q[k] <= data_in;
                end
            end
        end
    end

    always_comb begin
        entries = '0;
        for (int unsigned k = 0; k < N_ENTRIES; k++) begin
            entries[k*DATA_W +: DATA_W] = entry_q[k];
        end
    end

    assign entry_cnt = cnt_q;
    assign full      = (state_q == FULL);
    assign busy      = (state_q == SORT);
    assign start     = start_q;

endmodule

// File: tb/tb_sort_entry_loader.sv
// Scoreboard bench: stimulus pushes expected output snapshots, a negedge monitor compares each observed change.
module tb_sort_entry_loader;

    typedef struct packed {
        logic [15:0] ent;
        logic [2:0]  cnt;
        logic        full;
        logic        start;
        logic        busy;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_n = 1'b1;
    logic        go_n = 1'b1;
    logic [3:0]  data_in = '0;
    logic        sort_done = 1'b0;
    logic [15:0] entries;
    logic [2:0]  entry_cnt;
    logic        full;
    logic        start;
    logic        busy;

    snap_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    fails = 0;
    int    req_cnt = 0;
    int    seen_cnt = 0;
    bit    mon_en = 1'b0;
    bit    final_req = 1'b0;
    bit    final_done = 1'b0;
    snap_t prev = '1;

    always #5 clk = ~clk;

    sort_entry_loader #(
        .DATA_W          (4),
        .N_ENTRIES       (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_n    (load_n),
        .go_n      (go_n),
        .data_in   (data_in),
        .sort_done (sort_done),
        .entries   (entries),
        .entry_cnt (entry_cnt),
        .full      (full),
        .start     (start),
        .busy      (busy)
    );

    function automatic snap_t mk(input logic [15:0] e, input logic [2:0] c,
                                 input logic f, input logic s, input logic b);
        snap_t r;
        r.ent = e; r.cnt = c; r.full = f; r.start = s; r.busy = b;
        return r;
    endfunction

    task automatic expect_snap(input string nm, input snap_t s);
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Press one or both buttons for low_cyc cycles, then release and let the release settle.
    task automatic press(input bit l, input bit g, input logic [3:0] d, input int low_cyc);
        data_in = d;
        load_n  = ~l;
        go_n    = ~g;
        tick(low_cyc);
        load_n = 1'b1;
        go_n   = 1'b1;
        tick(12);
    endtask

    task automatic pulse_done();
        sort_done = 1'b1;
        tick(1);
        sort_done = 1'b0;
        tick(4);
    endtask

    always @(negedge clk) begin
        snap_t cur;
        snap_t e;
        string nm;
        if (mon_en) begin
            cur = mk(entries, entry_cnt, full, start, busy);
            if ((cur !== prev) || (req_cnt != seen_cnt)) begin
                seen_cnt = req_cnt;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change act ent=%h cnt=%0d full=%b start=%b busy=%b, required no change",
                             cur.ent, cur.cnt, cur.full, cur.start, cur.busy);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL %s act ent=%h cnt=%0d full=%b start=%b busy=%b req ent=%h cnt=%0d full=%b start=%b busy=%b",
                                 nm, cur.ent, cur.cnt, cur.full, cur.start, cur.busy,
                                 e.ent, e.cnt, e.full, e.start, e.busy);
                    end
                end
                prev = cur;
            end
        end
        if (final_req && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL pending_expectations act %0d outstanding, req 0 (next: %s)",
                         exp_q.size(), name_q[0]);
            end
            final_done = 1'b1;
        end
    end

    initial begin
        tick(2);
        // Reset state sampled while still holding reset
        expect_snap("reset_state", mk(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0));
        mon_en  = 1'b1;
        req_cnt = req_cnt + 1;
        tick(1);
        rst_n = 1'b1;
        tick(3);

        pulse_done();

        expect_snap("load_9", mk(16'h0009, 3'd1, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'h9, 10);
        expect_snap("load_3", mk(16'h0039, 3'd2, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'h3, 10);

        press(1'b0, 1'b1, 4'h3, 10);

        // Bounce: 3 low, 2 high, then 10 low gives a single write
        expect_snap("bounce_load_C", mk(16'h0C39, 3'd3, 1'b0, 1'b0, 1'b0));
        data_in = 4'hC;
        load_n  = 1'b0;
        tick(3);
        load_n = 1'b1;
        tick(2);
        press(1'b1, 1'b0, 4'hC, 10);

        expect_snap("load_1_full", mk(16'h1C39, 3'd4, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'h1, 10);

        press(1'b1, 1'b0, 4'h7, 10);

        expect_snap("simul_full_start", mk(16'h1C39, 3'd4, 1'b0, 1'b1, 1'b1));
        expect_snap("simul_full_busy", mk(16'h1C39, 3'd4, 1'b0, 1'b0, 1'b1));
        press(1'b1, 1'b1, 4'hE, 10);

        press(1'b1, 1'b0, 4'h2, 10);
        press(1'b0, 1'b1, 4'h2, 10);

        expect_snap("sort_done_rearm", mk(16'h1C39, 3'd0, 1'b0, 1'b0, 1'b0));
        pulse_done();

        expect_snap("simul_collect_write", mk(16'h1C35, 3'd1, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b1, 4'h5, 10);

        expect_snap("reload_6", mk(16'h1C65, 3'd2, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'h6, 10);
        expect_snap("reload_7", mk(16'h1765, 3'd3, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'h7, 10);
        expect_snap("reload_8_full", mk(16'h8765, 3'd4, 1'b1, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'h8, 10);

        expect_snap("go_start", mk(16'h8765, 3'd4, 1'b0, 1'b1, 1'b1));
        expect_snap("go_busy", mk(16'h8765, 3'd4, 1'b0, 1'b0, 1'b1));
        press(1'b0, 1'b1, 4'h8, 10);

        // Reset mid-sort with both buttons held; neither may fire after release
        expect_snap("reset_mid_sort", mk(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0));
        data_in = 4'hB;
        load_n  = 1'b0;
        go_n    = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        load_n = 1'b1;
        go_n   = 1'b1;
        tick(12);

        expect_snap("load_A_after_reset", mk(16'h000A, 3'd1, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, 4'hA, 10);

        tick(5);
        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) begin
            tick(1);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/sort_entry_loader.md
# sort_entry_loader

Upstream input stage for the bubble-sort machine. Converts raw active-low push-button presses and the switch nibble into four loaded entries, then issues a one-cycle start pulse to the sort datapath. Holds off further entry while the sort runs, and re-arms when the datapath reports completion. Debounced press detection is handled inside the block, so the sorter sees only clean, single-cycle events.

## Interface

Parameters:
- DATA_W, 4, width of each entry (matches the switch nibble)
- N_ENTRIES, 4, number of entries collected before a sort may start
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz)

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- load_n  in  1  raw "load entry" button, active-low, asynchronous to clk
- go_n  in  1  raw "start sort" button, active-low, asynchronous to clk
- data_in  in  DATA_W  switch value, quasi-static
- sort_done  in  1  one-cycle pulse from the datapath when the sort completes
- entries  out  N_ENTRIES*DATA_W  packed entries; entry k occupies bits [k*DATA_W +: DATA_W]
- entry_cnt  out  $clog2(N_ENTRIES+1)  number of entries loaded in the current round (0..N_ENTRIES)
- full  out  1  high when entry_cnt == N_ENTRIES and the block is not sorting
- start  out  1  one-cycle pulse that launches the sort
- busy  out  1  high while a sort is in flight

## Operation

- Each button path runs through a 2-FF synchronizer, then the debouncer, then a press detector. A press event is a one-cycle pulse generated on the debounced transition from released (1) to pressed (0). Releases produce no event.
- data_in is not synchronized. It is sampled only on a load press event, by which time the switches have been stable for at least the debounce window.
- FSM states:
  - COLLECT (reset state): a load event writes data_in into entries[entry_cnt] and increments entry_cnt. When entry_cnt reaches N_ENTRIES, the FSM moves to FULL. Go events are ignored in this state.
  - FULL: a go event asserts start for one cycle and moves the FSM to SORT. Load events are ignored in this state.
  - SORT: busy=1. All button events are ignored. On sort_done, the FSM goes to COLLECT and entry_cnt resets to 0. Entries keep their values until they are overwritten.
- Simultaneous load and go events in the same cycle: the event valid for the current state acts, and the other is dropped.
- sort_done outside SORT is ignored.
- Reset (any state, including mid-debounce or mid-sort) causes the following:
  - FSM goes to COLLECT.
  - entry_cnt, all entries, start and busy go to 0; full goes to 0.
  - Debounced levels go to 1 (released), debounce counters go to 0, and synchronizer flops go to 1.
  - A button already held through reset release produces no event until it is released and pressed again.
- Widths: entry_cnt never exceeds N_ENTRIES and never wraps. No write occurs when entry_cnt == N_ENTRIES.

## Timing

- Synchronizer latency: 2 cycles.
- Debouncer: the counter increments each cycle that the synchronized input differs from the debounced level, and clears whenever they match. The debounced level flips on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter then clears. Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- Press event: asserted the cycle after the debounced level falls. Registered outputs (entries, entry_cnt, full, start) update on the next clock edge after the event.
- start is high for exactly one cycle. busy rises in the same cycle as start and falls the cycle after sort_done is sampled. full falls in the same cycle that start rises.
- Every press, from its raw edge onward, produces at most one event.

## Structure

- Shared package `sort_pkg`:
  - state enum (COLLECT, FULL, SORT)
  - DATA_W and N_ENTRIES defaults shared with the datapath
- Sub-module `key_debounce`: synchronizer plus debounce counter plus press-pulse output, parameterized by DEBOUNCE_CYCLES. It is instantiated twice, once for load_n and once for go_n.
- The FSM and the entry registers live in the top of this block.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- Reset: drive rst_n=0 for 2 cycles → entries=0, entry_cnt=0, full=0, start=0, busy=0.
- Load sequence: four clean load presses with data_in = 9, 3, C, 1 → entries = {1,C,3,9} (entry3..entry0), entry_cnt=4, full=1. A fifth load press leaves all state unchanged.
- Bounce rejection: load_n low for 3 cycles, high for 2, then low for 10 → exactly one write occurs, and entry_cnt increments by 1.
- Start handshake:
  - Go press in COLLECT with entry_cnt=2 → no start.
  - Go press in FULL → start=1 for one cycle, then busy=1.
  - Load and go presses during SORT → ignored.
  - sort_done pulse → busy=0, entry_cnt=0, FSM in COLLECT, entries unchanged.
- Simultaneous events: in FULL, load and go events in the same cycle → start pulses and entries are unchanged. In COLLECT, the same stimulus → one write and no start.
- Mid-operation reset: assert rst_n=0 during SORT while go_n is held low → all outputs return to reset values. No event fires after reset release until go_n is released and pressed again.
